// File: rtl/sprite_dma.sv
// sprite_dma: snoops CPU writes to $4014, freezes the core and copies one 256-byte page to $2004.
// Optional macro SPRITE_DMA_ALIGN_EN adds a parity register and an ALIGN state so every READ lands on parity 0.
module sprite_dma (
    input  logic        clk,
    input  logic        reset,
    input  logic        ce,
    input  logic [15:0] cpu_aout,
    input  logic [7:0]  cpu_dout,
    input  logic        cpu_mr,
    input  logic        cpu_mw,
    input  logic [7:0]  din,
    output logic        cpu_ce,
    output logic        pause,
    output logic [15:0] aout,
    output logic [7:0]  dout,
    output logic        mr,
    output logic        mw
);

`ifdef SPRITE_DMA_ALIGN_EN
    typedef enum logic [2:0] {IDLE, HALT, ALIGN, READ, WRITE} dmaStateT;
`else
    typedef enum logic [2:0] {IDLE, HALT, READ, WRITE} dmaStateT;
`endif

    dmaStateT    state;
    dmaStateT    stateNext;
    logic [7:0]  page;
    logic [7:0]  idx;
    logic [7:0]  data;
    logic        trigger;

    assign trigger = cpu_mw && (cpu_aout == 16'h4014);

`ifdef SPRITE_DMA_ALIGN_EN
    logic parity;

    always_ff @(posedge clk) begin
        if (reset)
            parity <= 1'b0;
        else if (ce)
            parity <= ~parity;
    end
`endif

    // NOTE: every variable gets a default before the case, so no latch is inferred.
    always_comb begin
        stateNext = state;
        case (state)
            IDLE:  if (trigger) stateNext = HALT;
`ifdef SPRITE_DMA_ALIGN_EN
            HALT:  stateNext = parity ? READ : ALIGN;
            ALIGN: stateNext = READ;
`else
            HALT:  stateNext = READ;
`endif
            READ:  stateNext = WRITE;
            WRITE: stateNext = (idx == 8'hFF) ? IDLE : READ;
            default: stateNext = IDLE;
        endcase
    end

    // Bus mux: pass-through while idle, engine-owned otherwise.
    always_comb begin
        aout = 16'h0000;
        dout = data;
        mr   = 1'b0;
        mw   = 1'b0;
        case (state)
            IDLE: begin
                aout = cpu_aout;
                dout = cpu_dout;
                mr   = cpu_mr;
                mw   = cpu_mw;
            end
            READ: begin
                aout = {page, idx};
                mr   = 1'b1;
            end
            WRITE: begin
                aout = 16'h2004;
                mw   = 1'b1;
            end
            default: ;
        endcase
    end

    assign pause  = (state != IDLE);
    assign cpu_ce = ce & ~pause;

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            page  <= 8'h00;
            idx   <= 8'h00;
            data  <= 8'h00;
        end else if (ce) begin
            state <= stateNext;
            if (state == IDLE && trigger) begin
                page <= cpu_dout;
                idx  <= 8'h00;
            end
            if (state == READ)
                data <= din;
            if (state == WRITE)
                idx <= idx + 8'd1;
        end
    end

endmodule

// File: tb/tb_sprite_dma.sv
// Self-checking bench for sprite_dma: queued expectations for DMA reads/writes, checked by a negedge monitor.
module tb_sprite_dma;

    logic        clk = 1'b0;
    logic        reset;
    logic        ce;
    logic [15:0] cpu_aout;
    logic [7:0]  cpu_dout;
    logic        cpu_mr;
    logic        cpu_mw;
    logic [7:0]  din;
    logic        cpu_ce;
    logic        pause;
    logic [15:0] aout;
    logic [7:0]  dout;
    logic        mr;
    logic        mw;

    logic [7:0]  mem [0:65535];
    logic [7:0]  expData[$];
    logic [15:0] expAddr[$];
    int          checks   = 0;
    int          fails    = 0;
    int          pauseCnt = 0;
    int          wrCount  = 0;
    bit          throttle = 1'b0;
    bit          alignOn;
    logic        tbPar;

    sprite_dma dut (
        .clk      (clk),
        .reset    (reset),
        .ce       (ce),
        .cpu_aout (cpu_aout),
        .cpu_dout (cpu_dout),
        .cpu_mr   (cpu_mr),
        .cpu_mw   (cpu_mw),
        .din      (din),
        .cpu_ce   (cpu_ce),
        .pause    (pause),
        .aout     (aout),
        .dout     (dout),
        .mr       (mr),
        .mw       (mw)
    );

    always #5 clk = ~clk;

    assign din = mem[aout];

    // Bench-side parity tracker: toggles on every ce cycle, cleared by reset.
    always @(posedge clk) begin
        if (reset)
            tbPar <= 1'b0;
        else if (ce)
            tbPar <= ~tbPar;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
        ce = throttle ? ~ce : 1'b1;
    endtask

    task automatic passCheck(input string name);
        check({name, "_pause"}, {31'd0, pause}, 32'd0);
        check({name, "_cpu_ce"}, {31'd0, cpu_ce}, {31'd0, ce});
        check({name, "_aout"}, {16'd0, aout}, {16'd0, cpu_aout});
        check({name, "_mr"}, {31'd0, mr}, {31'd0, cpu_mr});
        check({name, "_mw"}, {31'd0, mw}, {31'd0, cpu_mw});
        if (cpu_mw)
            check({name, "_dout"}, {24'd0, dout}, {24'd0, cpu_dout});
    endtask

    // Scoreboard monitor: pops expected read addresses and write data as the DUT presents them.
    always @(negedge clk) begin
        logic [15:0] a;
        logic [7:0]  d;
        if (!reset && ce && pause) begin
            pauseCnt++;
            if (mr) begin
                if (expAddr.size() == 0) begin
                    check("rd_unexpected", {16'd0, aout}, 32'hFFFF_FFFF);
                end else begin
                    a = expAddr.pop_front();
                    check("rd_addr", {16'd0, aout}, {16'd0, a});
                end
            end
            if (mw) begin
                check("wr_addr", {16'd0, aout}, 32'h0000_2004);
                if (expData.size() == 0) begin
                    check("wr_unexpected", {24'd0, dout}, 32'hFFFF_FFFF);
                end else begin
                    d = expData.pop_front();
                    check("wr_data", {24'd0, dout}, {24'd0, d});
                end
                wrCount++;
            end
        end
    end

    // Issue the $4014 trigger and queue the hand-computed expectations for the whole page.
    task automatic startCopy(input logic [7:0] pg, output int expLen);
        for (int i = 0; i < 256; i++) begin
            expAddr.push_back({pg, i[7:0]});
            expData.push_back((pg == 8'hFF) ? (8'hFF - i[7:0]) : i[7:0]);
        end
        expLen   = (alignOn && tbPar == 1'b1) ? 514 : 513;
        pauseCnt = 0;
        wrCount  = 0;
        cpu_aout = 16'h4014;
        cpu_dout = pg;
        cpu_mw   = 1'b1;
        @(negedge clk);
        check("trig_write_passes", {16'd0, aout, 7'd0, mw}, {16'd0, 16'h4014, 8'd1});
        cycle();
        cpu_mw   = 1'b0;
        cpu_aout = 16'h0000;
        cpu_dout = 8'h00;
        @(negedge clk);
        check("pause_rise", {31'd0, pause}, 32'd1);
        check("cpu_ce_frozen", {31'd0, cpu_ce}, 32'd0);
    endtask

    task automatic finishCopy(input string name, input int expLen);
        for (int k = 0; k < 3000 && pause; k++)
            cycle();
        throttle = 1'b0;
        ce       = 1'b1;
        check({name, "_done"}, {31'd0, pause}, 32'd0);
        check({name, "_len"}, pauseCnt, expLen);
        check({name, "_writes"}, wrCount, 32'd256);
        check({name, "_q_empty"}, expData.size() + expAddr.size(), 32'd0);
    endtask

    task automatic runCopy(input string name, input logic [7:0] pg, input bit wantPar, input bit thr);
        int expLen;
        if (tbPar != wantPar)
            cycle();
        startCopy(pg, expLen);
        throttle = thr;
        finishCopy(name, expLen);
    endtask

    initial begin
        int expLen;
`ifdef SPRITE_DMA_ALIGN_EN
        alignOn = 1'b1;
`else
        alignOn = 1'b0;
`endif
        for (int i = 0; i < 65536; i++)
            mem[i] = 8'h00;
        for (int i = 0; i < 256; i++) begin
            mem[16'h0200 + i] = i[7:0];
            mem[16'hFF00 + i] = 8'hFF - i[7:0];
        end

        reset    = 1'b1;
        ce       = 1'b1;
        cpu_aout = 16'h0000;
        cpu_dout = 8'h00;
        cpu_mr   = 1'b0;
        cpu_mw   = 1'b0;
        cycle();
        cycle();

        // Reset state and pass-through
        reset    = 1'b0;
        cpu_aout = 16'h1234;
        cpu_dout = 8'hC3;
        @(negedge clk);
        passCheck("reset_state");
        cycle();
        cpu_aout = 16'h0300;
        cpu_dout = 8'h5A;
        cpu_mw   = 1'b1;
        @(negedge clk);
        passCheck("pt_write");
        cycle();
        cpu_mw = 1'b0;
        cpu_mr = 1'b1;
        @(negedge clk);
        passCheck("pt_read");
        cycle();
        cpu_mr = 1'b0;

        // Basic copies, one with HALT on parity 0 and one on parity 1
        runCopy("copy_halt_p0", 8'h02, 1'b1, 1'b0);
        runCopy("copy_halt_p1", 8'h02, 1'b0, 1'b0);

        // ce throttled copy
        runCopy("copy_throttle", 8'h02, 1'b1, 1'b1);

        // Reset after the 100th $2004 write, then a fresh copy
        startCopy(8'h02, expLen);
        for (int k = 0; k < 1000 && wrCount < 100; k++)
            cycle();
        check("rst_mid_count", wrCount, 32'd100);
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        expData.delete();
        expAddr.delete();
        cpu_aout = 16'h0456;
        cpu_mr   = 1'b1;
        @(negedge clk);
        passCheck("rst_mid_pt");
        cycle();
        cpu_mr   = 1'b0;
        cpu_aout = 16'h0000;
        runCopy("copy_after_rst", 8'h02, tbPar, 1'b0);

        // Page FF: reads $FF00-$FFFF, no re-trigger on idx wrap
        runCopy("copy_page_ff", 8'hFF, tbPar, 1'b0);
        for (int k = 0; k < 4; k++) begin
            cycle();
            check("no_retrigger", {31'd0, pause}, 32'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
